// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for serial_adder.
// With SERIAL_ADDER_OVF_EN defined the bundle also carries the signed overflow flag ovf.
interface serial_adder_if #(
   parameter int unsigned WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
   logic             ovf;

   modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
   modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`else
   modport master (output start, a, b, cin, input busy, done, sum, cout);
   modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: captures a, b, cin on start, then adds LSB first through a
// single full_adder, one bit per clock, with a start/busy/done handshake.
// Optional feature macro: SERIAL_ADDER_OVF_EN adds the registered signed overflow output ovf.

// One-bit full adder cell, purely combinational.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic sum_c,
   output logic carry_c
);
   assign sum_c   = a ^ b ^ ci;
   assign carry_c = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder #(
   parameter int unsigned WIDTH = 8
) (
   input logic           clk,
   input logic           rst,
   serial_adder_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
   localparam int unsigned ACC_W = WIDTH - 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state, state_nxt;
   logic [WIDTH-1:0]   sh_a, sh_a_nxt;
   logic [WIDTH-1:0]   sh_b, sh_b_nxt;
   // Holds the WIDTH-1 sum bits produced so far; the last bit joins on completion.
   logic [ACC_W-1:0]   acc, acc_nxt;
   logic               carry, carry_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic               busy, busy_nxt;
   logic               done, done_nxt;
   logic [WIDTH-1:0]   sum, sum_nxt;
   logic               cout, cout_nxt;
`ifdef SERIAL_ADDER_OVF_EN
   logic               ovf, ovf_nxt;
`endif
   logic               fa_s, fa_c;

   full_adder u_fa (
      .a       (sh_a[0]),
      .b       (sh_b[0]),
      .ci      (carry),
      .sum_c   (fa_s),
      .carry_c (fa_c)
   );

   // Next-state, datapath and registered-output values.
   always_comb begin
      state_nxt = state;
      sh_a_nxt  = sh_a;
      sh_b_nxt  = sh_b;
      acc_nxt   = acc;
      carry_nxt = carry;
      cnt_nxt   = cnt;
      busy_nxt  = busy;
      done_nxt  = 1'b0;
      sum_nxt   = sum;
      cout_nxt  = cout;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_nxt   = ovf;
`endif
      case (state)
         IDLE: begin
            busy_nxt = 1'b0;
            if (bus.start) begin
               sh_a_nxt  = bus.a;
               sh_b_nxt  = bus.b;
               carry_nxt = bus.cin;
               cnt_nxt   = '0;
               acc_nxt   = '0;
               busy_nxt  = 1'b1;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            acc_nxt   = ACC_W'({fa_s, acc} >> 1);
            sh_a_nxt  = sh_a >> 1;
            sh_b_nxt  = sh_b >> 1;
            carry_nxt = fa_c;
            cnt_nxt   = cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH - 1)) begin
               sum_nxt   = {fa_s, acc};
               cout_nxt  = fa_c;
`ifdef SERIAL_ADDER_OVF_EN
               // carry still holds the carry into the MSB during this step
               ovf_nxt   = carry ^ fa_c;
`endif
               busy_nxt  = 1'b0;
               done_nxt  = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         sh_a  <= '0;
         sh_b  <= '0;
         acc   <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf   <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         sh_a  <= sh_a_nxt;
         sh_b  <= sh_b_nxt;
         acc   <= acc_nxt;
         carry <= carry_nxt;
         cnt   <= cnt_nxt;
         busy  <= busy_nxt;
         done  <= done_nxt;
         sum   <= sum_nxt;
         cout  <= cout_nxt;
`ifdef SERIAL_ADDER_OVF_EN
         ovf   <= ovf_nxt;
`endif
      end
   end

   assign bus.busy = busy;
   assign bus.done = done;
   assign bus.sum  = sum;
   assign bus.cout = cout;
`ifdef SERIAL_ADDER_OVF_EN
   assign bus.ovf  = ovf;
`endif
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed cases plus randomized
// operations, checked every cycle against a transaction-level timeline model.
// Define SERIAL_ADDER_OVF_EN to also exercise the ovf output.
module tb_serial_adder;
   localparam int unsigned W  = 8;
   localparam int unsigned W1 = W + 1;

   logic clk = 1'b0;
   logic rst;
   bit   chk_en = 1'b0;
   int   tests = 0;
   int   fails = 0;

   serial_adder_if #(.WIDTH(W)) bus ();

   serial_adder #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Timeline model: result is plain a+b+cin, published WIDTH edges after acceptance.
   int           m_phase = 0;   // 0 idle, 1 adding, 2 done pulse
   int           m_left  = 0;
   logic [W:0]   m_res   = '0;
   logic         m_busy  = 1'b0;
   logic         m_done  = 1'b0;
   logic [W-1:0] m_sum   = '0;
   logic         m_cout  = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
   logic         m_povf  = 1'b0;
   logic         m_ovf   = 1'b0;
`endif

   always @(posedge clk) begin
      if (rst) begin
         m_phase = 0; m_busy = 1'b0; m_done = 1'b0; m_sum = '0; m_cout = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         m_ovf = 1'b0;
`endif
      end else begin
         case (m_phase)
            0: begin
               m_done = 1'b0;
               if (bus.start) begin
                  m_res  = W1'(bus.a) + W1'(bus.b) + W1'(bus.cin);
`ifdef SERIAL_ADDER_OVF_EN
                  m_povf = (bus.a[W-1] == bus.b[W-1]) && (m_res[W-1] != bus.a[W-1]);
`endif
                  m_left  = W;
                  m_phase = 1;
                  m_busy  = 1'b1;
               end
            end
            1: begin
               m_left--;
               if (m_left == 0) begin
                  m_phase = 2; m_busy = 1'b0; m_done = 1'b1;
                  m_sum = m_res[W-1:0]; m_cout = m_res[W];
`ifdef SERIAL_ADDER_OVF_EN
                  m_ovf = m_povf;
`endif
               end
            end
            default: begin
               m_phase = 0; m_done = 1'b0;
            end
         endcase
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check("busy", 32'(bus.busy), 32'(m_busy));
         check("done", 32'(bus.done), 32'(m_done));
         check("sum",  32'(bus.sum),  32'(m_sum));
         check("cout", 32'(bus.cout), 32'(m_cout));
`ifdef SERIAL_ADDER_OVF_EN
         check("ovf",  32'(bus.ovf),  32'(m_ovf));
`endif
      end
   end

   // One operation from IDLE; returns cycles until done, busy cycles, and whether done appeared.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         output int ncyc, output int nbusy, output bit seen);
      ncyc = 0; nbusy = 0; seen = 1'b0;
      @(negedge clk);
      bus.start = 1'b1; bus.a = a; bus.b = b; bus.cin = cin;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (i == 0) bus.start = 1'b0;
         ncyc++;
         if (bus.busy) nbusy++;
         if (bus.done) begin
            seen = 1'b1;
            break;
         end
      end
      check("done_seen", 32'(seen), 32'(1));
   endtask

   task automatic wait_done();
      bit seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.done) begin
            seen = 1'b1;
            break;
         end
      end
      check("wait_done", 32'(seen), 32'(1));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int ncyc, nbusy, nd, mode;
      bit seen;
      logic [W-1:0] ra, rb, cap;
      logic rc;

      rst = 1'b1; bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(bus.busy), 32'(0));
      check("rst_done", 32'(bus.done), 32'(0));
      check("rst_sum",  32'(bus.sum),  32'(0));
      check("rst_cout", 32'(bus.cout), 32'(0));
      rst = 1'b0;
      chk_en = 1'b1;

      // 5A + 3C: latency and busy length
      run_op(8'h5A, 8'h3C, 1'b0, ncyc, nbusy, seen);
      check("lat_5a3c",  32'(ncyc),     32'(W + 1));
      check("busy_len",  32'(nbusy),    32'(W));
      check("sum_5a3c",  32'(bus.sum),  32'(8'h96));
      check("cout_5a3c", 32'(bus.cout), 32'(0));

      // FF + 01, then FF + FF + 1 with the old result held meanwhile
      run_op(8'hFF, 8'h01, 1'b0, ncyc, nbusy, seen);
      check("sum_ff01",  32'(bus.sum),  32'(8'h00));
      check("cout_ff01", 32'(bus.cout), 32'(1));
      @(negedge clk);
      bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'hFF; bus.cin = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      check("held_sum",  32'(bus.sum),  32'(8'h00));
      check("held_cout", 32'(bus.cout), 32'(1));
      wait_done();
      check("sum_ffff1",  32'(bus.sum),  32'(8'hFF));
      check("cout_ffff1", 32'(bus.cout), 32'(1));

      // start plus new operands during SHIFT are ignored
      @(negedge clk);
      bus.start = 1'b1; bus.a = 8'h12; bus.b = 8'h34; bus.cin = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (2) @(negedge clk);
      bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'hFF;
      nd = 0; cap = '0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.done) begin
            nd++; cap = bus.sum; bus.start = 1'b0;
         end
      end
      bus.start = 1'b0;
      check("ign_ndone", 32'(nd),  32'(1));
      check("ign_sum",   32'(cap), 32'(8'h46));

      // reset on the 4th SHIFT edge aborts without a done pulse
      @(negedge clk);
      bus.start = 1'b1; bus.a = 8'h05; bus.b = 8'h06; bus.cin = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("abort_busy", 32'(bus.busy), 32'(0));
      check("abort_done", 32'(bus.done), 32'(0));
      check("abort_sum",  32'(bus.sum),  32'(0));
      check("abort_cout", 32'(bus.cout), 32'(0));
      rst = 1'b0;
      nd = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus.done) nd++;
      end
      check("abort_nodone", 32'(nd), 32'(0));
      run_op(8'h01, 8'h02, 1'b0, ncyc, nbusy, seen);
      check("sum_0102", 32'(bus.sum), 32'(8'h03));

      // start held high for 30 cycles: one result every WIDTH+2 cycles
      @(negedge clk);
      bus.start = 1'b1; bus.a = 8'h10; bus.b = 8'h20; bus.cin = 1'b0;
      nd = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (bus.done) begin
            nd++;
            check("hold_sum", 32'(bus.sum), 32'(8'h30));
         end
      end
      bus.start = 1'b0;
      check("hold_ndone", 32'(nd), 32'(3));
      repeat (3) @(negedge clk);

`ifdef SERIAL_ADDER_OVF_EN
      run_op(8'h7F, 8'h01, 1'b0, ncyc, nbusy, seen);
      check("ovf_7f01_sum",  32'(bus.sum),  32'(8'h80));
      check("ovf_7f01_ovf",  32'(bus.ovf),  32'(1));
      check("ovf_7f01_cout", 32'(bus.cout), 32'(0));
      run_op(8'h80, 8'h80, 1'b0, ncyc, nbusy, seen);
      check("ovf_8080_sum",  32'(bus.sum),  32'(8'h00));
      check("ovf_8080_ovf",  32'(bus.ovf),  32'(1));
      check("ovf_8080_cout", 32'(bus.cout), 32'(1));
      run_op(8'hFF, 8'h01, 1'b0, ncyc, nbusy, seen);
      check("ovf_ff01_ovf",  32'(bus.ovf),  32'(0));
`endif

      // randomized operations with occasional aborts and ignored starts
      for (int n = 0; n < 300; n++) begin
         ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
         mode = int'($urandom_range(0, 9));
         repeat ($urandom_range(0, 3)) @(negedge clk);
         if (mode == 0) begin
            @(negedge clk);
            bus.start = 1'b1; bus.a = ra; bus.b = rb; bus.cin = rc;
            @(negedge clk);
            bus.start = 1'b0;
            repeat ($urandom_range(0, W - 1)) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
         end else if (mode == 1) begin
            @(negedge clk);
            bus.start = 1'b1; bus.a = ra; bus.b = rb; bus.cin = rc;
            @(negedge clk);
            bus.start = 1'b0;
            @(negedge clk);
            bus.start = 1'b1; bus.a = W'($urandom); bus.b = W'($urandom); bus.cin = 1'($urandom);
            repeat ($urandom_range(1, 4)) @(negedge clk);
            bus.start = 1'b0;
            wait_done();
            check("rnd_ign_sum", 32'({bus.cout, bus.sum}), 32'(W1'(ra) + W1'(rb) + W1'(rc)));
         end else begin
            run_op(ra, rb, rc, ncyc, nbusy, seen);
            check("rnd_lat", 32'(ncyc), 32'(W + 1));
            check("rnd_sum", 32'({bus.cout, bus.sum}), 32'(W1'(ra) + W1'(rb) + W1'(rc)));
         end
      end

      repeat (3) @(negedge clk);
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial adder: registers two WIDTH-bit operands and a carry-in, then adds them LSB first, one bit per clock.
- Each step runs through a single instance of the team's full_adder cell.
- A carry flip-flop closes the loop around that cell, and the sum bits are collected in a shift register.
- Trades WIDTH cycles of latency for one full-adder's worth of logic; uses a start/busy/done handshake.

Parameters:
- WIDTH, 8, operand and sum width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepted start edge.
- b  input  WIDTH  operand B; captured on the accepted start edge.
- cin  input  1  carry-in; captured on the accepted start edge.
- busy  output  1  high while an addition is in progress (SHIFT state).
- done  output  1  one-cycle pulse when sum/cout become valid.
- sum  output  WIDTH  result; registered and held until the next completion.
- cout  output  1  final carry-out; registered and held like sum.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; busy=0, done=0, sum=0, cout=0.
  - Operand shift registers, carry flip-flop and bit counter are cleared.
  - rst has priority over every other input and aborts an operation in progress; no done pulse follows.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at edge E: load shA=a, shB=b, carry=cin, cnt=0, acc=0; go to SHIFT (busy=1 from E).
  - start=0: stay in IDLE.
- SHIFT, one bit per edge:
  - Full-adder inputs are shA[0], shB[0], carry; outputs are s and c.
  - acc <= {s, acc[WIDTH-1:1]}; shA and shB shift right with zero fill; carry <= c; cnt <= cnt+1.
  - On the edge that processes bit WIDTH-1 (cnt==WIDTH-1):
    - sum <= {s, acc[WIDTH-1:1]}; cout <= c.
    - Go to DONE; busy=0, done=1.
- DONE: lasts exactly one cycle, then IDLE unconditionally; done returns to 0.
- Latency:
  - Start accepted at edge E gives done=1 and valid sum/cout after edge E+WIDTH.
  - The next start can be accepted at edge E+WIDTH+2 at the earliest; throughput is one addition per WIDTH+2 cycles.
- start while busy or in DONE: ignored, no queuing. Operand changes after the capture edge have no effect.
- sum and cout change only on completion or reset; they never show partial results during SHIFT.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). Unsigned, no saturation.
- Counter width is clog2(WIDTH)+1 bits; it never wraps within an operation.
- start held high continuously: a new operation starts every WIDTH+2 cycles.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit, reset 0), updated together with sum/cout.
  - ovf = signed two's-complement overflow = (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1).
  - Requires registering the carry value held during the final SHIFT step.
- Not defined: ovf port and its logic are absent; all other behaviour is identical.

Test Plan (WIDTH=8):
- a=8'h5A, b=8'h3C, cin=0, start pulsed at edge E -> busy high for 8 cycles; done=1 exactly one cycle after edge E+8; sum=8'h96, cout=0.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1. Previous result is held until the new done.
- start=1 and changed a/b during SHIFT (issued 3 cycles after the accepted start) -> ignored; result is from the original operands; only one done pulse.
- rst=1 at the 4th SHIFT edge -> busy=0, sum=0, cout=0, no done. A new start afterwards with a=8'h01, b=8'h02 -> sum=8'h03.
- start held high for 30 cycles with a=8'h10, b=8'h20 -> done pulses every 10 cycles, sum=8'h30 each time.
- SERIAL_ADDER_OVF_EN defined:
  - a=8'h7F, b=8'h01 -> sum=8'h80, ovf=1, cout=0.
  - a=8'h80, b=8'h80 -> sum=8'h00, ovf=1, cout=1.
  - a=8'hFF, b=8'h01 -> ovf=0.
